// File: rtl/writeback_l6.sv
// L6 writeback stage: round-robin arbitration over the X__W pipes into one W register,
// which drives the register-file write and commit message. Optional bypass ports: WRITEBACK_L6_BYPASS_EN.
module writeback_l6 #(
   parameter int p_num_pipes    = 2,
   parameter int p_seq_num_bits = 5
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [p_num_pipes-1:0]                        X_val,
   output logic [p_num_pipes-1:0]                        X_rdy,
   input  logic [p_num_pipes-1:0][31:0]                  X_pc,
   input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]    X_seq_num,
   input  logic [p_num_pipes-1:0][4:0]                   X_waddr,
   input  logic [p_num_pipes-1:0][31:0]                  X_wdata,
   input  logic [p_num_pipes-1:0]                        X_wen,
   output logic                                          rf_wen,
   output logic [4:0]                                    rf_waddr,
   output logic [31:0]                                   rf_wdata,
   output logic                                          commit_val,
   input  logic                                          commit_rdy,
   output logic [31:0]                                   commit_pc,
   output logic [p_seq_num_bits-1:0]                     commit_seq_num,
   output logic [4:0]                                    commit_waddr,
   output logic [31:0]                                   commit_wdata,
   output logic                                          commit_wen
`ifdef WRITEBACK_L6_BYPASS_EN
   ,
   output logic                                          fwd_val,
   output logic [4:0]                                    fwd_waddr,
   output logic [31:0]                                   fwd_wdata
`endif
);

   localparam int PW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

   logic                      r_val;
   logic [31:0]               r_pc;
   logic [p_seq_num_bits-1:0] r_seq_num;
   logic [4:0]                r_waddr;
   logic [31:0]               r_wdata;
   logic                      r_wen;
   logic [PW-1:0]             r_ptr;

   logic                      w_can_accept;
   logic                      w_any;
   logic [p_num_pipes-1:0]    w_grant;
   logic [PW-1:0]             w_sel;
   logic [PW-1:0]             w_ptr_nxt;
   logic                      w_xfer;
   logic                      w_eff_wen;

   // Rotating priority in two passes: pipes at or above ptr first, then the wrapped-around ones.
   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < p_num_pipes; i++) begin
         if (!w_any && X_val[i] && (PW'(i) >= r_ptr)) begin
            w_grant[i] = 1'b1;
            w_any      = 1'b1;
            w_sel      = PW'(i);
         end
      end
      for (int i = 0; i < p_num_pipes; i++) begin
         if (!w_any && X_val[i] && (PW'(i) < r_ptr)) begin
            w_grant[i] = 1'b1;
            w_any      = 1'b1;
            w_sel      = PW'(i);
         end
      end
   end

   assign w_can_accept = !r_val || commit_rdy;
   assign X_rdy        = w_grant & {p_num_pipes{w_can_accept}};
   assign w_xfer       = w_any && w_can_accept;
   assign w_ptr_nxt    = (w_sel == PW'(p_num_pipes - 1)) ? '0 : w_sel + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_val     <= 1'b0;
         r_pc      <= '0;
         r_seq_num <= '0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_wen     <= 1'b0;
         r_ptr     <= '0;
      end else if (w_xfer) begin
         r_val     <= 1'b1;
         r_pc      <= X_pc[w_sel];
         r_seq_num <= X_seq_num[w_sel];
         r_waddr   <= X_waddr[w_sel];
         r_wdata   <= X_wdata[w_sel];
         r_wen     <= X_wen[w_sel];
         r_ptr     <= w_ptr_nxt;
      end else if (commit_rdy) begin
         r_val     <= 1'b0;
      end
   end

   // Writes to x0 still commit but never reach the register file.
   assign w_eff_wen      = r_wen && (r_waddr != 5'd0);

   assign commit_val     = r_val;
   assign commit_pc      = r_pc;
   assign commit_seq_num = r_seq_num;
   assign commit_waddr   = r_waddr;
   assign commit_wdata   = r_wdata;
   assign commit_wen     = w_eff_wen;

   assign rf_wen         = r_val && commit_rdy && w_eff_wen;
   assign rf_waddr       = r_waddr;
   assign rf_wdata       = r_wdata;

`ifdef WRITEBACK_L6_BYPASS_EN
   assign fwd_val        = r_val && w_eff_wen;
   assign fwd_waddr      = r_waddr;
   assign fwd_wdata      = r_wdata;
`endif

endmodule

// File: doc/writeback_l6.md
# writeback_l6

Writeback stage for the L6 processor. It is the receiving end of the X__W interface: it accepts completed results from `p_num_pipes` execute units (ALU, multiplier, memory, ...) through per-pipe val/rdy handshakes. A round-robin arbiter picks one result per cycle and holds it in a single W-stage register. From that register the block writes the register file and presents a commit message to the downstream commit/scoreboard logic.

## Interface
- `p_num_pipes`, default 2: number of X__W input ports (≥1).
- `p_seq_num_bits`, default 5: sequence-number width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `X_val` in `[p_num_pipes]`: per-pipe result valid.
- `X_rdy` out `[p_num_pipes]`: per-pipe accept.
- `X_pc` in `[p_num_pipes][32]`: instruction PC.
- `X_seq_num` in `[p_num_pipes][p_seq_num_bits]`: sequence number.
- `X_waddr` in `[p_num_pipes][5]`: destination register.
- `X_wdata` in `[p_num_pipes][32]`: result data.
- `X_wen` in `[p_num_pipes]`: result writes a register.
- `rf_wen` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `commit_val` out 1: commit message valid.
- `commit_rdy` in 1: commit message accepted.
- `commit_pc` out 32: PC of the committing instruction.
- `commit_seq_num` out `p_seq_num_bits`: sequence number.
- `commit_waddr` out 5: destination register.
- `commit_wdata` out 32: result data.
- `commit_wen` out 1: effective write flag.

## Operation
- State:
  - W register: `w_val` plus `pc`, `seq_num`, `waddr`, `wdata`, `wen`.
  - Round-robin pointer `ptr` (`$clog2(p_num_pipes)` bits, minimum 1).
- `can_accept = !w_val || commit_rdy`.
- Arbitration:
  - Scan pipes starting at `ptr`, ascending with wrap-around.
  - The first pipe with `X_val` high is granted.
  - `X_rdy[i] = can_accept && grant[i]`. At most one `X_rdy` is high per cycle.
  - `X_rdy` is never high for a pipe whose `X_val` is low.
- Transfer on `X_val[i] && X_rdy[i]`:
  - W register loads pipe i's fields and `w_val` is set.
  - `ptr` becomes `(i+1) mod p_num_pipes`.
- If `can_accept` is high and no pipe is valid: `w_val` clears when the current entry commits; `ptr` is unchanged.
- If `commit_rdy` is low while `w_val` is high: W register holds, all `X_rdy` are low, `ptr` is unchanged.
- Commit outputs:
  - `commit_val = w_val`.
  - `commit_*` fields are driven from the W register.
  - `commit_wen = wen && (waddr != 0)`.
- Register-file write:
  - `rf_wen = commit_val && commit_rdy && commit_wen`.
  - `rf_waddr` and `rf_wdata` come from the W register.
  - A writeback is performed exactly once per instruction.
- x0 results (`waddr == 0`): never written; they still commit with `commit_wen = 0`.
- Reset values: `w_val = 0`, `ptr = 0`, all W fields = 0.
  - Hence `commit_val`, `rf_wen` and `commit_wen` are 0, and `X_rdy` reflects arbitration on an empty register.
- Reset mid-operation: asynchronous clear; any held result is discarded and never written.

## Timing
- Latency: an input handshake in cycle c gives `commit_val = 1` in cycle c+1.
  - With `commit_rdy` high in c+1, `rf_wen` pulses in c+1.
- Throughput: one result per cycle with `commit_rdy` tied high.
  - The W register commits and reloads in the same cycle.
- `X_rdy` depends combinationally on `X_val`, `ptr`, `w_val` and `commit_rdy`.
- `commit_*` and `rf_*` depend only on registered state and `commit_rdy`; no input-to-commit combinational path.
- Simultaneous valid on all pipes: each pipe is served within `p_num_pipes` accepted transfers (no starvation).

## Configuration
- `WRITEBACK_L6_BYPASS_EN` defined: adds output ports `fwd_val` (1), `fwd_waddr` (5) and `fwd_wdata` (32).
  - `fwd_val = w_val && wen && (waddr != 0)`.
  - Fields come from the W register; this lets decode forward results before commit.
- Undefined: these ports do not exist; all other behaviour is identical.

## Test plan
- Single pipe:
  - Stimulus: pipe 0 sends pc=0x200, seq=3, waddr=5, wdata=0x2A, wen=1; `commit_rdy=1`.
  - Response: next cycle `commit_val=1`, `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0x2A`, seq=3.
- Contention:
  - Stimulus: pipes 0 and 1 both valid from reset, wdata 0x11 and 0x22.
  - Response: pipe 0 accepted first and commits 0x11, then pipe 1 commits 0x22 on consecutive cycles; `ptr` returns to 0.
- x0 write:
  - Stimulus: waddr=0, wen=1, wdata=0xFFFFFFFF.
  - Response: `commit_val=1`, `commit_wen=0`, `rf_wen=0`.
- Backpressure:
  - Stimulus: `commit_rdy=0` for 3 cycles with a held result and pipe 1 valid.
  - Response: all `X_rdy=0`, commit fields stable, no `rf_wen`. When `commit_rdy` rises, the held result commits and pipe 1 is accepted in the same cycle.
- Throughput: 8 back-to-back results on pipe 0 with `commit_rdy=1` → 8 commits in 8 consecutive cycles, in order.
- Reset:
  - Stimulus: assert `rst` while `w_val=1`.
  - Response: `commit_val` drops immediately, no `rf_wen`, `ptr=0` after deassert.
